// File: rtl/rs_pkg.sv
// Shared types for the ALU reservation station: the entry record and widths.
// Tags are stored at a fixed width; the top zero-extends ROB tags into it.
package rs_pkg;
  localparam int CMD_W    = 10;
  localparam int DATA_W   = 64;
  localparam int RS_TAG_W = 16;

  typedef struct packed {
    logic                valid;
    logic [CMD_W-1:0]    commands;
    logic [RS_TAG_W-1:0] tag;
    logic [DATA_W-1:0]   val1;
    logic [DATA_W-1:0]   val2;
    logic                rdy1;
    logic                rdy2;
    logic [RS_TAG_W-1:0] src1_tag;
    logic [RS_TAG_W-1:0] src2_tag;
  } rs_entry_t;
endpackage

// File: rtl/rs_entry.sv
// One station entry: holds a dispatched instruction and snoops the CDB for
// its missing operands, including a result broadcast on the dispatch edge.
module rs_entry
  import rs_pkg::*;
(
  input  logic                gclk,
  input  logic                grst_n,
  input  logic                flush,
  input  logic                wr_en,
  input  rs_entry_t           wr_data,
  input  logic                clr,
  input  logic                cdb_valid,
  input  logic [RS_TAG_W-1:0] cdb_tag,
  input  logic [DATA_W-1:0]   cdb_val,
  output rs_entry_t           entry,
  output logic                elig
);
  rs_entry_t q, nxt;

  always_comb begin
    nxt = wr_en ? wr_data : q;
    // Snooping the post-write value gives the dispatch-edge bypass for free.
    if (cdb_valid && nxt.valid) begin
      if (!nxt.rdy1 && nxt.src1_tag == cdb_tag) begin
        nxt.val1 = cdb_val;
        nxt.rdy1 = 1'b1;
      end
      if (!nxt.rdy2 && nxt.src2_tag == cdb_tag) begin
        nxt.val2 = cdb_val;
        nxt.rdy2 = 1'b1;
      end
    end
    if (clr) nxt.valid = 1'b0;
  end

  always_ff @(posedge gclk) begin
    if (!grst_n)    q       <= '0;
    else if (flush) q.valid <= 1'b0;
    else            q       <= nxt;
  end

  assign entry = q;
  assign elig  = q.valid & q.rdy1 & q.rdy2;
endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: RSdepth entries with CDB wakeup, oldest-first
// selection via an age matrix, and a single stallable issue slot.
module alu_reservation_station
  import rs_pkg::*;
#(
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int RSdepth    = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  flush_i,
  input  logic                  dispatchValid_i,
  output logic                  dispatchReady_o,
  input  logic [CMD_W-1:0]      dispatchCommands_i,
  input  logic [ROBsizeLog-1:0] dispatchTag_i,
  input  logic [DATA_W-1:0]     dispatchVal1_i,
  input  logic [DATA_W-1:0]     dispatchVal2_i,
  input  logic                  dispatchRdy1_i,
  input  logic                  dispatchRdy2_i,
  input  logic [ROBsizeLog-1:0] dispatchSrc1Tag_i,
  input  logic [ROBsizeLog-1:0] dispatchSrc2Tag_i,
  input  logic                  cdbValid_i,
  input  logic [ROBsizeLog-1:0] cdbTag_i,
  input  logic [DATA_W-1:0]     cdbVal_i,
  output logic [DATA_W-1:0]     reservationStationVal1_o,
  output logic [DATA_W-1:0]     reservationStationVal2_o,
  output logic [CMD_W-1:0]      reservationStationCommands_o,
  output logic [ROBsizeLog-1:0] reservationStationTag_o,
  output logic                  readyRS_o,
  input  logic                  stallRS_i
);
  localparam int IDX_W = (RSdepth > 1) ? $clog2(RSdepth) : 1;

  rs_entry_t                       ent [RSdepth];
  rs_entry_t                       wr_data;
  logic [RSdepth-1:0]              valid_vec, elig, wr_sel, wr_en, iss_sel, clr;
  // older[j][i] set means entry j was dispatched before entry i.
  logic [RSdepth-1:0][RSdepth-1:0] older;
  logic [IDX_W-1:0]                iss_idx;
  logic                            accept, any_elig, load, ready_q;

  always_comb begin
    wr_data          = '0;
    wr_data.valid    = 1'b1;
    wr_data.commands = dispatchCommands_i;
    wr_data.tag      = RS_TAG_W'(dispatchTag_i);
    wr_data.val1     = dispatchVal1_i;
    wr_data.val2     = dispatchVal2_i;
    wr_data.rdy1     = dispatchRdy1_i;
    wr_data.rdy2     = dispatchRdy2_i;
    wr_data.src1_tag = RS_TAG_W'(dispatchSrc1Tag_i);
    wr_data.src2_tag = RS_TAG_W'(dispatchSrc2Tag_i);
  end

  for (genvar i = 0; i < RSdepth; i++) begin : g_ent
    rs_entry u_ent (
      .gclk      (clk_i),
      .grst_n    (reset_i),
      .flush     (flush_i),
      .wr_en     (wr_en[i]),
      .wr_data   (wr_data),
      .clr       (clr[i]),
      .cdb_valid (cdbValid_i),
      .cdb_tag   (RS_TAG_W'(cdbTag_i)),
      .cdb_val   (cdbVal_i),
      .entry     (ent[i]),
      .elig      (elig[i])
    );
    assign valid_vec[i] = ent[i].valid;
    logic unused_bits;
    assign unused_bits = ^{ent[i].rdy1, ent[i].rdy2, ent[i].src1_tag, ent[i].src2_tag, ent[i].tag};
  end

  // Fullness uses registered valids only, so a same-edge issue frees nothing.
  assign dispatchReady_o = ~&valid_vec;
  assign accept          = dispatchValid_i & dispatchReady_o;

  always_comb begin
    logic found;
    wr_sel = '0;
    found  = 1'b0;
    for (int i = 0; i < RSdepth; i++) begin
      if (!valid_vec[i] && !found) begin
        wr_sel[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end
  assign wr_en = accept ? wr_sel : '0;

  always_comb begin
    logic blocked;
    iss_sel = '0;
    iss_idx = '0;
    for (int i = 0; i < RSdepth; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < RSdepth; j++)
        if (j != i && elig[j] && older[j][i]) blocked = 1'b1;
      if (elig[i] && !blocked) begin
        iss_sel[i] = 1'b1;
        iss_idx    = IDX_W'(i);
      end
    end
  end

  assign any_elig = |elig;
  assign load     = (!ready_q || !stallRS_i) && any_elig;
  assign clr      = load ? iss_sel : '0;

  // A new entry is younger than everything; stale rows of free entries are
  // rewritten when those entries are next allocated.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      older <= '0;
    end else begin
      for (int k = 0; k < RSdepth; k++) begin
        if (wr_en[k]) begin
          for (int j = 0; j < RSdepth; j++) begin
            older[k][j] <= 1'b0;
            older[j][k] <= (j != k);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      ready_q                      <= 1'b0;
      reservationStationVal1_o     <= '0;
      reservationStationVal2_o     <= '0;
      reservationStationCommands_o <= '0;
      reservationStationTag_o      <= '0;
    end else if (flush_i) begin
      ready_q <= 1'b0;
    end else if (!ready_q || !stallRS_i) begin
      ready_q <= any_elig;
      if (any_elig) begin
        reservationStationVal1_o     <= ent[iss_idx].val1;
        reservationStationVal2_o     <= ent[iss_idx].val2;
        reservationStationCommands_o <= ent[iss_idx].commands;
        reservationStationTag_o      <= ent[iss_idx].tag[ROBsizeLog-1:0];
      end
    end
  end

  assign readyRS_o = ready_q;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station with hand-computed expectations.
module tb_alu_reservation_station;
  localparam int TW = 6;

  logic          clk_i = 1'b0;
  logic          reset_i, flush_i, dispatchValid_i, dispatchReady_o;
  logic [9:0]    dispatchCommands_i;
  logic [TW-1:0] dispatchTag_i, dispatchSrc1Tag_i, dispatchSrc2Tag_i, cdbTag_i;
  logic [63:0]   dispatchVal1_i, dispatchVal2_i, cdbVal_i;
  logic          dispatchRdy1_i, dispatchRdy2_i, cdbValid_i;
  logic [63:0]   rs_val1, rs_val2;
  logic [9:0]    rs_cmd;
  logic [TW-1:0] rs_tag;
  logic          readyRS_o, stallRS_i;

  int checks = 0;
  int errors = 0;

  alu_reservation_station dut (
    .clk_i                        (clk_i),
    .reset_i                      (reset_i),
    .flush_i                      (flush_i),
    .dispatchValid_i              (dispatchValid_i),
    .dispatchReady_o              (dispatchReady_o),
    .dispatchCommands_i           (dispatchCommands_i),
    .dispatchTag_i                (dispatchTag_i),
    .dispatchVal1_i               (dispatchVal1_i),
    .dispatchVal2_i               (dispatchVal2_i),
    .dispatchRdy1_i               (dispatchRdy1_i),
    .dispatchRdy2_i               (dispatchRdy2_i),
    .dispatchSrc1Tag_i            (dispatchSrc1Tag_i),
    .dispatchSrc2Tag_i            (dispatchSrc2Tag_i),
    .cdbValid_i                   (cdbValid_i),
    .cdbTag_i                     (cdbTag_i),
    .cdbVal_i                     (cdbVal_i),
    .reservationStationVal1_o     (rs_val1),
    .reservationStationVal2_o     (rs_val2),
    .reservationStationCommands_o (rs_cmd),
    .reservationStationTag_o      (rs_tag),
    .readyRS_o                    (readyRS_o),
    .stallRS_i                    (stallRS_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic disp(input logic [TW-1:0] tag, input logic [63:0] v1, input logic [63:0] v2,
                      input logic r1, input logic r2, input logic [TW-1:0] s1, input logic [TW-1:0] s2);
    dispatchValid_i    = 1'b1;
    dispatchCommands_i = 10'd10;
    dispatchTag_i      = tag;
    dispatchVal1_i     = v1;
    dispatchVal2_i     = v2;
    dispatchRdy1_i     = r1;
    dispatchRdy2_i     = r2;
    dispatchSrc1Tag_i  = s1;
    dispatchSrc2Tag_i  = s2;
  endtask

  task automatic cdb(input logic v, input logic [TW-1:0] tag, input logic [63:0] val);
    cdbValid_i = v;
    cdbTag_i   = tag;
    cdbVal_i   = val;
  endtask

  initial begin
    reset_i = 1'b0; flush_i = 1'b0; stallRS_i = 1'b0;
    dispatchValid_i = 1'b0; dispatchCommands_i = '0; dispatchTag_i = '0;
    dispatchVal1_i = '0; dispatchVal2_i = '0; dispatchRdy1_i = 1'b0; dispatchRdy2_i = 1'b0;
    dispatchSrc1Tag_i = '0; dispatchSrc2Tag_i = '0;
    cdb(1'b0, '0, '0);
    step(); step();
    chk("rst_ready", readyRS_o, 0);
    chk("rst_dready", dispatchReady_o, 1);
    chk("rst_val1", rs_val1, 0);
    chk("rst_tag", rs_tag, 0);
    chk("rst_cmd", rs_cmd, 0);
    reset_i = 1'b1;
    step();

    // Both operands ready: issue one edge after acceptance
    disp(3, 15, 3, 1, 1, 0, 0);
    step();
    dispatchValid_i = 1'b0;
    chk("lat_e0_ready", readyRS_o, 0);
    step();
    chk("lat_ready", readyRS_o, 1);
    chk("lat_val1", rs_val1, 15);
    chk("lat_val2", rs_val2, 3);
    chk("lat_tag", rs_tag, 3);
    chk("lat_cmd", rs_cmd, 10);
    step();
    chk("lat_drop", readyRS_o, 0);

    // Wakeup of operand 1 from the CDB
    disp(5, 0, 7, 0, 1, 2, 0);
    step();
    dispatchValid_i = 1'b0;
    step();
    cdb(1'b1, 2, 64'h42);
    step();
    cdb(1'b0, 0, 0);
    chk("wake_notyet", readyRS_o, 0);
    step();
    chk("wake_ready", readyRS_o, 1);
    chk("wake_val1", rs_val1, 64'h42);
    chk("wake_val2", rs_val2, 7);
    chk("wake_tag", rs_tag, 5);
    step();
    chk("wake_drop", readyRS_o, 0);

    // Fill the station; full refuses dispatch even on the issuing edge
    for (int i = 0; i < 4; i++) begin
      disp(TW'(10 + i), 0, 1, 0, 1, TW'(20 + i), 0);
      step();
    end
    dispatchValid_i = 1'b0;
    chk("full_dready", dispatchReady_o, 0);
    cdb(1'b1, 22, 64'h99);
    disp(30, 1, 1, 1, 1, 0, 0);
    step();
    cdb(1'b0, 0, 0);
    chk("full_still", dispatchReady_o, 0);
    chk("full_noissue", readyRS_o, 0);
    step();
    dispatchValid_i = 1'b0;
    chk("full_iss_ready", readyRS_o, 1);
    chk("full_iss_tag", rs_tag, 12);
    chk("full_iss_val1", rs_val1, 64'h99);
    chk("full_dready_back", dispatchReady_o, 1);
    step();
    chk("full_refused", readyRS_o, 0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;

    // Oldest-first: tag 7 sits in a higher index than the younger tag 4
    disp(1, 0, 0, 0, 1, 50, 0);
    step();
    disp(7, 0, 2, 0, 1, 40, 0);
    step();
    dispatchValid_i = 1'b0;
    cdb(1'b1, 50, 64'h11);
    step();
    cdb(1'b0, 0, 0);
    step();
    chk("age_first_tag", rs_tag, 1);
    disp(4, 0, 3, 0, 1, 40, 0);
    step();
    dispatchValid_i = 1'b0;
    cdb(1'b1, 40, 64'h40);
    step();
    cdb(1'b0, 0, 0);
    step();
    chk("age_old_ready", readyRS_o, 1);
    chk("age_old_tag", rs_tag, 7);
    chk("age_old_val1", rs_val1, 64'h40);
    step();
    chk("age_young_tag", rs_tag, 4);
    chk("age_young_val2", rs_val2, 3);
    step();
    chk("age_drop", readyRS_o, 0);

    // Stall holds the slot
    stallRS_i = 1'b1;
    disp(8, 64'h80, 1, 1, 1, 0, 0);
    step();
    disp(9, 64'h90, 1, 1, 1, 0, 0);
    step();
    dispatchValid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", readyRS_o, 1);
      chk("stall_tag", rs_tag, 8);
      chk("stall_val1", rs_val1, 64'h80);
      step();
    end
    stallRS_i = 1'b0;
    step();
    chk("release_tag", rs_tag, 9);
    chk("release_ready", readyRS_o, 1);
    step();
    chk("release_drop", readyRS_o, 0);

    // Flush with a full slot and three waiting entries
    stallRS_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      disp(TW'(1 + i), 1, 1, 1, 1, 0, 0);
      step();
    end
    dispatchValid_i = 1'b0;
    chk("pre_flush_ready", readyRS_o, 1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    stallRS_i = 1'b0;
    chk("flush_ready", readyRS_o, 0);
    chk("flush_dready", dispatchReady_o, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_noissue", readyRS_o, 0);
    end

    // Reset mid-operation
    stallRS_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      disp(TW'(11 + i), 5, 5, 1, 1, 0, 0);
      step();
    end
    dispatchValid_i = 1'b0;
    reset_i = 1'b0;
    step();
    reset_i = 1'b1;
    stallRS_i = 1'b0;
    chk("mrst_ready", readyRS_o, 0);
    chk("mrst_dready", dispatchReady_o, 1);
    chk("mrst_tag", rs_tag, 0);
    chk("mrst_val1", rs_val1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mrst_noissue", readyRS_o, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_reservation_station.md
ALU_RESERVATION_STATION -- requirements
Module: alu_reservation_station

Interface
REQ-001 SHALL have parameter ROBsize, default 32, ROB entry count.
REQ-002 SHALL have parameter ROBsizeLog, default $clog2(ROBsize+1), tag width.
REQ-003 SHALL have parameter RSdepth, default 4, number of station entries (power of 2, >=2).
REQ-004 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-005 SHALL have port reset_i  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port flush_i  input  1  discard all entries and issue slot.
REQ-007 SHALL have port dispatchValid_i  input  1  dispatch request.
REQ-008 SHALL have port dispatchReady_o  output  1  station can accept.
REQ-009 SHALL have port dispatchCommands_i  input  10  command word; [4:2] ALU control.
REQ-010 SHALL have port dispatchTag_i  input  ROBsizeLog  destination ROB tag.
REQ-011 SHALL have ports dispatchVal1_i/dispatchVal2_i  input  64 each  operand values.
REQ-012 SHALL have ports dispatchRdy1_i/dispatchRdy2_i  input  1 each  operand already valid.
REQ-013 SHALL have ports dispatchSrc1Tag_i/dispatchSrc2Tag_i  input  ROBsizeLog each  producer tag when not ready.
REQ-014 SHALL have ports cdbValid_i  input  1, cdbTag_i  input  ROBsizeLog, cdbVal_i  input  64  result broadcast.
REQ-015 SHALL have ports reservationStationVal1_o/Val2_o  output  64, reservationStationCommands_o  output  10, reservationStationTag_o  output  ROBsizeLog  issue slot contents.
REQ-016 SHALL have port readyRS_o  output  1  issue slot holds a valid instruction.
REQ-017 SHALL have port stallRS_i  input  1  execute stage cannot accept.

Function
REQ-018 Dispatch SHALL be accepted at a rising edge iff dispatchValid_i && dispatchReady_o; written into a free entry with valid=1.
REQ-019 dispatchReady_o SHALL be low iff all RSdepth entries valid (registered state; slots freed same edge not counted).
REQ-020 Operand n SHALL be written ready with cdbVal_i if, at dispatch, dispatchRdyn_i=0, cdbValid_i=1 and cdbTag_i==dispatchSrcnTag_i (same-cycle bypass).
REQ-021 Each valid entry with an unready operand whose source tag equals cdbTag_i while cdbValid_i=1 SHALL capture cdbVal_i and mark it ready at that edge; both operands may wake in one edge.
REQ-022 An entry SHALL be eligible once valid with both operands ready; eligibility SHALL not be evaluated combinationally from the current-cycle CDB.
REQ-023 Issue slot SHALL load at an edge when (!readyRS_o || !stallRS_i) and an eligible entry exists; that entry SHALL be freed at the same edge.
REQ-024 Selection SHALL pick the oldest eligible entry (dispatch order), not lowest index.
REQ-025 When readyRS_o && stallRS_i, slot contents SHALL hold unchanged; when readyRS_o && !stallRS_i and nothing eligible, readyRS_o SHALL drop next edge.
REQ-026 Minimum latency: dispatch with both ready at edge E0 -> readyRS_o high after E1.
REQ-027 Dispatch and issue in the same edge SHALL both take effect; a full station issuing still SHALL refuse dispatch that cycle.
REQ-028 flush_i SHALL clear all entry valids and readyRS_o at the next edge, overriding dispatch, wakeup and issue.

Reset
REQ-029 On reset_i=0 at an edge: all entries invalid, readyRS_o=0, slot data/tag/commands=0, dispatchReady_o=1 after the edge.
REQ-030 Reset mid-operation SHALL discard all contents with no issue that edge.

Structure
REQ-031 Shared package rs_pkg SHALL hold the entry struct (valid, commands, tag, val1/2, rdy1/2, src1/2Tag) and the 10-bit command width constant.
REQ-032 Per-entry storage and CDB snoop SHALL be sub-module rs_entry, instantiated RSdepth times; age ordering and selection in the top.

Verification
REQ-033 Dispatch cmd=10, tag=3, val1=15, val2=3, both ready, stallRS_i=0 -> readyRS_o=1 one cycle after acceptance with those values, then 0.
REQ-034 Dispatch tag=5 src1Tag=2 unready; CDB tag=2 val=0x42 two cycles later -> issue with Val1=0x42 one cycle after broadcast.
REQ-035 Fill 4 entries with unready operands -> dispatchReady_o=0; broadcast waking entry 2 -> entry 2 issues, dispatchReady_o=1 next cycle.
REQ-036 Two entries become eligible same edge (tags 7 then 4 dispatched in that order) -> tag 7 issues first, tag 4 next.
REQ-037 readyRS_o=1 with stallRS_i=1 for 3 cycles -> outputs held stable; release -> next eligible entry loaded next edge.
REQ-038 flush_i (or reset_i=0) with 3 valid entries and slot full -> readyRS_o=0, dispatchReady_o=1 next cycle, no later issue of old tags.
